bcd_entry: RTL and testbench

BCD_ENTRY -- requirements
Module: bcd_entry

---
 rtl/bcd_entry.sv | 145 ++++++++++++++
 tb/tb_bcd_entry.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_entry.sv
// Two-digit BCD keypad entry: a debounced pushbutton samples a 4-bit switch digit
// twice (tens, then ones) and the registered result is published if it fits in 0..15.
module bcd_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       clr,
    input  logic [3:0] sw,
    output logic [3:0] value,
    output logic       valid,
    output logic       err,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_TENS = 2'd0,
        S_ONES = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    logic             r_key_s1, r_key_s2;
    logic             r_clr_s1, r_clr_s2;
    logic [3:0]       r_sw_s1, r_sw_s2;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_key_level;
    logic             r_key_level_d;
    logic             w_press;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_tens, w_tens_nxt;
    logic [3:0]       r_value, w_value_nxt;
    logic             w_done_nxt;
    logic             r_valid, r_err, r_busy, r_done;
    logic [4:0]       w_sum;

    // Synchronizers idle at the released / inactive levels.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_clr_s1 <= 1'b0;
            r_clr_s2 <= 1'b0;
            r_sw_s1  <= 4'd0;
            r_sw_s2  <= 4'd0;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_clr_s1 <= clr;
            r_clr_s2 <= r_clr_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Accept a new key level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt      <= '0;
            r_key_level   <= 1'b1;
            r_key_level_d <= 1'b1;
        end else begin
            r_key_level_d <= r_key_level;
            if (r_key_s2 == r_key_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db_cnt    <= '0;
                r_key_level <= r_key_s2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_key_level_d & ~r_key_level;

    // Five bits so that 19 (tens=1, ones=9) and worse are caught rather than wrapping.
    assign w_sum = 5'(r_tens) * 5'd10 + 5'(r_sw_s2);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_value_nxt = r_value;
        w_done_nxt  = 1'b0;
        if (r_clr_s2) begin
            w_state_nxt = S_TENS;
            w_value_nxt = 4'd0;
        end else if (w_press) begin
            if (r_state == S_ONES) begin
                w_done_nxt = 1'b1;
                if (r_sw_s2 > 4'd9 || w_sum > 5'd15) begin
                    w_state_nxt = S_ERR;
                    w_value_nxt = 4'd0;
                end else begin
                    w_state_nxt = S_DONE;
                    w_value_nxt = w_sum[3:0];
                end
            end else begin
                w_tens_nxt = r_sw_s2;
                if (r_sw_s2 > 4'd1) begin
                    w_state_nxt = S_ERR;
                    w_value_nxt = 4'd0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_ONES;
                end
            end
        end
    end

    // Status flags are registered from the next state so they align with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_TENS;
            r_tens  <= 4'd0;
            r_value <= 4'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tens  <= w_tens_nxt;
            r_value <= w_value_nxt;
            r_valid <= (w_state_nxt == S_DONE);
            r_err   <= (w_state_nxt == S_ERR);
            r_busy  <= (w_state_nxt == S_ONES);
            r_done  <= w_done_nxt;
        end
    end

    assign value = r_value;
    assign valid = r_valid;
    assign err   = r_err;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_bcd_entry.sv
// Directed and random two-digit entries on bcd_entry (DEBOUNCE_CYCLES=4), checked
// against an arithmetic model of the entry rules.
module tb_bcd_entry;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic       clr;
    logic [3:0] sw;
    logic [3:0] value;
    logic       valid;
    logic       err;
    logic       busy;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt;

    // Expected state of the entry, derived from the digit rules.
    int m_tens;
    bit m_busy;
    bit m_valid;
    bit m_err;
    int m_value;
    int exp_done;

    bcd_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .clr   (clr),
        .sw    (sw),
        .value (value),
        .valid (valid),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tens = 0; m_busy = 0; m_valid = 0; m_err = 0; m_value = 0; exp_done = 0;
    endtask

    task automatic model_press(input int d);
        if (!m_busy) begin
            if (d > 1) begin
                m_err = 1; m_valid = 0; m_value = 0; exp_done = 1;
            end else begin
                m_tens = d; m_busy = 1; m_valid = 0; m_err = 0; exp_done = 0;
            end
        end else begin
            m_busy = 0;
            exp_done = 1;
            if (d > 9 || m_tens * 10 + d > 15) begin
                m_err = 1; m_valid = 0; m_value = 0;
            end else begin
                m_err = 0; m_valid = 1; m_value = m_tens * 10 + d;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_value"}, int'(value), m_value);
        check({tag, "_valid"}, int'(valid), int'(m_valid));
        check({tag, "_err"},   int'(err),   int'(m_err));
        check({tag, "_busy"},  int'(busy),  int'(m_busy));
    endtask

    // One keypress with digit d; optional bounce; clr pulsed at hold cycle clr_at (-1: none).
    task automatic press(input string tag, input logic [3:0] d, input bit bounce, input int clr_at);
        sw = d;
        repeat (3) @(negedge clk);
        done_cnt = 0;
        if (bounce) begin
            repeat (2) begin
                key_n = 1'b0;
                repeat (3) @(negedge clk);
                key_n = 1'b1;
                repeat (3) @(negedge clk);
            end
            repeat (3) @(negedge clk);
            check({tag, "_bounce_done"}, done_cnt, 0);
            check({tag, "_bounce_busy"}, int'(busy), int'(m_busy));
        end
        key_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            clr = (i == clr_at);
            @(negedge clk);
        end
        clr = 1'b0;
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        if (clr_at >= 0) model_reset();
        else model_press(int'(d));
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        clr   = 1'b0;
        sw    = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1 then 3 -> 13
        press("e13_tens", 4'd1, 1'b0, -1);
        press("e13_ones", 4'd3, 1'b0, -1);
        // bouncing press: still exactly one event
        press("bounce_tens", 4'd0, 1'b1, -1);
        press("bounce_ones", 4'd4, 1'b0, -1);
        // 17 out of range, then 09
        press("e17_tens", 4'd1, 1'b0, -1);
        press("e17_ones", 4'd7, 1'b0, -1);
        press("e09_tens", 4'd0, 1'b0, -1);
        press("e09_ones", 4'd9, 1'b0, -1);
        // tens digit 2 is immediately an error; ones digit 0xA is an error
        press("tens2", 4'd2, 1'b0, -1);
        press("e1A_tens", 4'd1, 1'b0, -1);
        press("e1A_ones", 4'hA, 1'b0, -1);

        // Asynchronous reset while waiting for the ones digit discards the tens digit
        press("rst_tens", 4'd1, 1'b0, -1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        press("e05_tens", 4'd0, 1'b0, -1);
        press("e05_ones", 4'd5, 1'b0, -1);

        // clr coincident with the ones press event
        press("clr_tens", 4'd1, 1'b0, -1);
        press("clr_ones", 4'd2, 1'b0, 4);

        // Key held low through reset release yields one press event
        sw = 4'd1;
        key_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        done_cnt = 0;
        repeat (14) @(negedge clk);
        model_press(1);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        check("held_rst_done_cnt", done_cnt, exp_done);
        check_outputs("held_rst");
        press("held_rst_ones", 4'd1, 1'b0, -1);

        // Random entries; sw wiggles between presses must not disturb the outputs
        for (int k = 0; k < 24; k++) begin
            logic [3:0] d;
            d = (k % 3 == 0) ? 4'($urandom_range(0, 15)) :
                (m_busy ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 1)));
            press($sformatf("rnd%0d", k), d, bit'($urandom_range(0, 1)), -1);
            sw = 4'($urandom_range(0, 15));
            repeat (4) @(negedge clk);
            check_outputs($sformatf("rnd%0d_swq", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
